// File: rtl/alarm_scan_ctrl.sv
// Alarm-match sequencer: on each second tick, walks the time/alarm digits through an external
// comparator, detects a full HH:MM:SS match and drives a bounded ring. Optional snooze: ALARM_SNOOZE_EN.
module alarm_scan_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sec_tick,
  input  logic [23:0] time_bcd,
  input  logic [23:0] alarm_bcd,
  input  logic        alarm_on,
  input  logic        stop,
`ifdef ALARM_SNOOZE_EN
  input  logic        snooze,
`endif
  output logic [3:0]  cmp_a,
  output logic [3:0]  cmp_b,
  output logic        cmp_en,
  input  logic        cmp_l,
  input  logic        cmp_e,
  input  logic        cmp_r,
  output logic        match,
  output logic        ring,
  output logic        busy,
  output logic        cmp_err
);

  localparam int unsigned    CNT_MAX_INT = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam bit               SNOOZE_BUILT = 1'b1;
  localparam logic [CNT_W-1:0] SNOOZE_LAST  = CNT_W'(SNOOZE_SECS - 1);
`else
  localparam bit               SNOOZE_BUILT = 1'b0;
`endif

  // Counter must be wide enough for every timeout that is compiled in.
  if ((RING_SECS > CNT_MAX_INT) || (SNOOZE_BUILT && (SNOOZE_SECS > CNT_MAX_INT))) begin : g_cnt_w_check
    $error("alarm_scan_ctrl: CNT_W too small for configured timeouts");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
`ifdef ALARM_SNOOZE_EN
    S_RING = 2'd2,
    S_SNOOZE = 2'd3
`else
    S_RING = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [23:0]      tsnap_q, tsnap_d;
  logic [23:0]      asnap_q, asnap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cmp_a_q, cmp_a_d;
  logic [3:0]       cmp_b_q, cmp_b_d;
  logic             cmp_en_q, cmp_en_d;
  logic             match_q, match_d;
  logic             ring_q, ring_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             onehot_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [2:0]       idx_dec_c;

  function automatic logic [3:0] digit(input logic [23:0] v, input logic [2:0] i);
    case (i)
      3'd5:    digit = v[23:20];
      3'd4:    digit = v[19:16];
      3'd3:    digit = v[15:12];
      3'd2:    digit = v[11:8];
      3'd1:    digit = v[7:4];
      default: digit = v[3:0];
    endcase
  endfunction

  assign onehot_c  = (cmp_l ^ cmp_e ^ cmp_r) & ~(cmp_l & cmp_e & cmp_r);
  assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign idx_dec_c = idx_q - 3'd1;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      tsnap_q  <= 24'd0;
      asnap_q  <= 24'd0;
      cnt_q    <= '0;
      cmp_a_q  <= 4'd0;
      cmp_b_q  <= 4'd0;
      cmp_en_q <= 1'b0;
      match_q  <= 1'b0;
      ring_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tsnap_q  <= tsnap_d;
      asnap_q  <= asnap_d;
      cnt_q    <= cnt_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      cmp_en_q <= cmp_en_d;
      match_q  <= match_d;
      ring_q   <= ring_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-output logic; comparator outputs are presented one cycle after the decision.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tsnap_d  = tsnap_q;
    asnap_d  = asnap_q;
    cnt_d    = cnt_q;
    cmp_a_d  = 4'd0;
    cmp_b_d  = 4'd0;
    cmp_en_d = 1'b0;
    match_d  = 1'b0;
    ring_d   = 1'b0;
    busy_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (sec_tick && alarm_on) begin
          tsnap_d  = time_bcd;
          asnap_d  = alarm_bcd;
          idx_d    = 3'd5;
          cmp_a_d  = digit(time_bcd, 3'd5);
          cmp_b_d  = digit(alarm_bcd, 3'd5);
          cmp_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!onehot_c) begin
          err_d = 1'b1;
        end
        if (!alarm_on) begin
          state_d = S_IDLE;
        end else if (onehot_c && cmp_e) begin
          if (idx_q == 3'd0) begin
            match_d = 1'b1;
            ring_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_RING;
          end else begin
            idx_d    = idx_dec_c;
            cmp_a_d  = digit(tsnap_q, idx_dec_c);
            cmp_b_d  = digit(asnap_q, idx_dec_c);
            cmp_en_d = 1'b1;
            busy_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RING: begin
        ring_d = 1'b1;
        if (stop || !alarm_on) begin
          ring_d  = 1'b0;
          state_d = S_IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          ring_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SNOOZE;
        end
`endif
        else if (sec_tick) begin
          if (cnt_q == RING_LAST) begin
            ring_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end

`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (stop || !alarm_on) begin
          state_d = S_IDLE;
        end else if (sec_tick) begin
          if (cnt_q == SNOOZE_LAST) begin
            ring_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_RING;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign cmp_a   = cmp_a_q;
  assign cmp_b   = cmp_b_q;
  assign cmp_en  = cmp_en_q;
  assign match   = match_q;
  assign ring    = ring_q;
  assign busy    = busy_q;
  assign cmp_err = err_q;

endmodule

// File: tb/tb_alarm_scan_ctrl.sv
// Directed bench for alarm_scan_ctrl with a behavioural digit comparator; RING_SECS=3, SNOOZE_SECS=2.
module tb_alarm_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sec_tick;
  logic [23:0] time_bcd;
  logic [23:0] alarm_bcd;
  logic        alarm_on;
  logic        stop;
`ifdef ALARM_SNOOZE_EN
  logic        snooze;
`endif
  logic [3:0]  cmp_a;
  logic [3:0]  cmp_b;
  logic        cmp_en;
  logic        cmp_l, cmp_e, cmp_r;
  logic        match, ring, busy, cmp_err;
  logic        bad_cmp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Comparator model; bad_cmp forces an illegal all-low result.
  assign cmp_l = !bad_cmp && (cmp_a > cmp_b);
  assign cmp_e = !bad_cmp && (cmp_a == cmp_b);
  assign cmp_r = !bad_cmp && (cmp_a < cmp_b);

  alarm_scan_ctrl #(.RING_SECS(3), .CNT_W(9), .SNOOZE_SECS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sec_tick  (sec_tick),
    .time_bcd  (time_bcd),
    .alarm_bcd (alarm_bcd),
    .alarm_on  (alarm_on),
    .stop      (stop),
`ifdef ALARM_SNOOZE_EN
    .snooze    (snooze),
`endif
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_en    (cmp_en),
    .cmp_l     (cmp_l),
    .cmp_e     (cmp_e),
    .cmp_r     (cmp_r),
    .match     (match),
    .ring      (ring),
    .busy      (busy),
    .cmp_err   (cmp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  // Tick with matching time/alarm and advance to T+7 (first ring cycle).
  task automatic run_match();
    time_bcd  = 24'h073000;
    alarm_bcd = 24'h073000;
    pulse_tick();
    for (int i = 0; i < 6; i++) step();
  endtask

  logic [3:0] exp_t [6];
  logic [3:0] exp_a [6];

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; alarm_on = 1'b1; stop = 1'b0; bad_cmp = 1'b0;
    time_bcd = 24'h0; alarm_bcd = 24'h0;
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b0;
`endif
    step();
    check("rst_ring", ring, 0);
    check("rst_match", match, 0);
    check("rst_busy", busy, 0);
    check("rst_cmp_en", cmp_en, 0);
    check("rst_cmp_err", cmp_err, 0);
    rst_n = 1'b1;
    step();

    // Full match 07:30:00
    exp_t = '{4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0};
    time_bcd = 24'h073000; alarm_bcd = 24'h073000;
    check("idle_cmp_en", cmp_en, 0);
    pulse_tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("m_en%0d", i), cmp_en, 1);
      check($sformatf("m_a%0d", i), cmp_a, exp_t[i]);
      check($sformatf("m_b%0d", i), cmp_b, exp_t[i]);
      check($sformatf("m_busy%0d", i), busy, 1);
      check($sformatf("m_match%0d", i), match, 0);
      step();
    end
    check("m_match_t7", match, 1);
    check("m_ring_t7", ring, 1);
    check("m_busy_t7", busy, 0);
    check("m_en_t7", cmp_en, 0);
    step();
    check("m_match_t8", match, 0);
    check("m_ring_t8", ring, 1);

    // Ring timeout after 3 ticks
    pulse_tick(); check("rt_ring1", ring, 1); step();
    pulse_tick(); check("rt_ring2", ring, 1); step();
    pulse_tick(); check("rt_ring3", ring, 0);
    step(); check("rt_busy", busy, 0);

    // Mismatch 07:31:00 vs 07:30:00: exits after H1,H0,M1,M0
    exp_t = '{4'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd0};
    exp_a = '{4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0};
    time_bcd = 24'h073100; alarm_bcd = 24'h073000;
    pulse_tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mm_en%0d", i), cmp_en, 1);
      check($sformatf("mm_a%0d", i), cmp_a, exp_t[i]);
      check($sformatf("mm_b%0d", i), cmp_b, exp_a[i]);
      step();
    end
    check("mm_en_t5", cmp_en, 0);
    check("mm_busy_t5", busy, 0);
    check("mm_match_t5", match, 0);
    check("mm_ring_t5", ring, 0);
    step(); step();
    check("mm_ring_late", ring, 0);

    // Stop after one tick
    run_match();
    check("st_ring", ring, 1);
    pulse_tick(); check("st_ring_tick", ring, 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("st_ring_off", ring, 0);

    // Stop beats a simultaneous tick; the tick does not start a scan
    run_match();
    stop = 1'b1; sec_tick = 1'b1; step(); stop = 1'b0; sec_tick = 1'b0;
    check("sp_ring_off", ring, 0);
    step(); check("sp_busy", busy, 0);

    // Snapshot isolates scan from time changes
    time_bcd = 24'h073000; alarm_bcd = 24'h073000;
    pulse_tick();
    time_bcd = 24'h125959;
    for (int i = 0; i < 6; i++) step();
    check("snap_match", match, 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("snap_ring_off", ring, 0);

    // Illegal comparator response sets sticky error, no match
    bad_cmp = 1'b1;
    time_bcd = 24'h073000; alarm_bcd = 24'h073000;
    pulse_tick();
    step();
    bad_cmp = 1'b0;
    check("err_set", cmp_err, 1);
    check("err_busy", busy, 0);
    check("err_en", cmp_en, 0);
    for (int i = 0; i < 6; i++) step();
    check("err_nomatch_ring", ring, 0);
    time_bcd = 24'h073100;
    pulse_tick();
    for (int i = 0; i < 6; i++) step();
    check("err_sticky", cmp_err, 1);

    // alarm_on dropped at T+3 aborts scan
    time_bcd = 24'h073000; alarm_bcd = 24'h073000;
    pulse_tick();
    step();
    step();
    check("ab_busy_t3", busy, 1);
    alarm_on = 1'b0;
    step();
    check("ab_busy_t4", busy, 0);
    check("ab_en_t4", cmp_en, 0);
    for (int i = 0; i < 4; i++) step();
    check("ab_match", match, 0);
    check("ab_ring", ring, 0);
    alarm_on = 1'b1;

    // Asynchronous reset while ringing
    run_match();
    check("ar_ring_pre", ring, 1);
    rst_n = 1'b0;
    #2;
    check("ar_ring", ring, 0);
    check("ar_match", match, 0);
    check("ar_busy", busy, 0);
    check("ar_en", cmp_en, 0);
    check("ar_err", cmp_err, 0);
    rst_n = 1'b1;
    step();
    run_match();
    check("ar_rematch", match, 1);
    check("ar_rering", ring, 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("ar_stop", ring, 0);

`ifdef ALARM_SNOOZE_EN
    // Snooze drops ring, re-rings after 2 ticks without match pulse
    run_match();
    snooze = 1'b1; step(); snooze = 1'b0;
    check("sn_ring_off", ring, 0);
    pulse_tick(); check("sn_tick1", ring, 0); step();
    pulse_tick(); check("sn_tick2_ring", ring, 1);
    check("sn_tick2_match", match, 0);
    // Stop and snooze together: IDLE, so a following tick starts a scan
    stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
    check("sn_both_ring", ring, 0);
    time_bcd = 24'h073100;
    pulse_tick();
    check("sn_both_busy", busy, 1);
    for (int i = 0; i < 6; i++) step();
    check("sn_both_noring", ring, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
